mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 58 +++++
 rtl/mdu_div_iter.sv | 52 +++++
 rtl/mdu_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, enums and defaults shared by the M-extension unit.
package mdu_pkg;

  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int DIV_STEPS       = 32;

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef enum logic [1:0] {
    MOP_MUL    = 2'b00,
    MOP_MULH   = 2'b01,
    MOP_MULHSU = 2'b10,
    MOP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL_WAIT,
    DIV_RUN,
    DIV_FIX,
    DONE
  } state_e;

  function automatic logic is_m_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_sdiv_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic mul_op_e mul_code(input logic [4:0] op);
    mul_op_e c;
    unique case (1'b1)
      (op == OP_MULH):   c = MOP_MULH;
      (op == OP_MULHSU): c = MOP_MULHSU;
      (op == OP_MULHU):  c = MOP_MULHU;
      default:           c = MOP_MUL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: 32-step restoring divider on unsigned magnitudes.
module mdu_div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] dsr;
  logic [5:0]  cnt;
  logic        run;
  logic [32:0] trial;

  // Borrow in bit 32 means the divisor did not fit: restore.
  assign trial = {rem, quo[31]} - {1'b0, dsr};
  assign last  = run && (cnt == 6'(DIV_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      run <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dsr <= '0;
    end else if (load) begin
      run <= 1'b1;
      cnt <= '0;
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
    end else if (run) begin
      if (trial[32]) begin
        rem <= {rem[30:0], quo[31]};
      end else begin
        rem <= trial[31:0];
      end
      quo <= {quo[30:0], ~trial[32]};
      cnt <= cnt + 1'b1;
      if (last) begin
        run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: M-extension sequencer (external multiplier, iterative divider).
// Define MDU_DIV_FASTPATH_EN to finish div-by-zero/overflow in one cycle.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [4:0]  alu_op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        err_o,
  output logic        mul_start_o,
  output logic [1:0]  mul_opcode_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_e      state;
  logic [4:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [CW-1:0] wcnt;
  logic        neg_q;
  logic        neg_r;
  logic        isrem_q;
  logic        spec_q;
  logic [31:0] spec_res_q;

  logic        accept;
  logic        in_div;
  logic        in_sgn;
  logic        in_rem;
  logic        in_dz;
  logic        in_ovf;
  logic        fast;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] spec_val;

  logic        div_load;
  logic        div_abort;
  logic        div_last;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] div_res;
  logic [31:0] mul_res;
  logic        mul_act;

  assign in_div = is_m_op(alu_op_i) && !is_mul_op(alu_op_i);
  assign in_sgn = is_sdiv_op(alu_op_i);
  assign in_rem = is_rem_op(alu_op_i);
  assign in_dz  = (src_b_i == '0);
  assign in_ovf = in_sgn && (src_a_i == 32'h8000_0000)
                  && (src_b_i == 32'hFFFF_FFFF);

  // Special cases bypass the divider's sign fix-up.
  assign spec_val = in_dz ? (in_rem ? src_a_i : 32'hFFFF_FFFF)
                          : (in_rem ? 32'h0 : 32'h8000_0000);

  assign a_mag = (in_sgn && src_a_i[31]) ? -src_a_i : src_a_i;
  assign b_mag = (in_sgn && src_b_i[31]) ? -src_b_i : src_b_i;

`ifdef MDU_DIV_FASTPATH_EN
  assign fast = in_dz || in_ovf;
`else
  assign fast = 1'b0;
`endif

  assign accept = !rst && (state == IDLE) && start_i
                  && !flush_i && is_m_op(alu_op_i);

  assign stall_o = accept
                   || (state == MUL_WAIT)
                   || (state == DIV_RUN)
                   || (state == DIV_FIX);

  assign mul_act      = (state == MUL_WAIT);
  assign mul_start_o  = mul_act && (wcnt == '0);
  assign mul_opcode_o = mul_act ? 2'(mul_code(op_q)) : 2'b00;
  assign mul_op1_o    = mul_act ? a_q : 32'h0;
  assign mul_op2_o    = mul_act ? b_q : 32'h0;

  assign mul_res = (op_q == OP_MUL) ? mul_result_i[31:0]
                                    : mul_result_i[63:32];

  assign div_load  = accept && in_div && !fast;
  assign div_abort = flush_i
                     && ((state == DIV_RUN) || (state == DIV_FIX));

  mdu_div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .abort    (div_abort),
    .dividend (a_mag),
    .divisor  (b_mag),
    .last     (div_last),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  assign q_fix   = neg_q ? -div_quo : div_quo;
  assign r_fix   = neg_r ? -div_rem : div_rem;
  assign div_res = spec_q ? spec_res_q
                          : (isrem_q ? r_fix : q_fix);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wcnt       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      isrem_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      result_o   <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= alu_op_i;
            a_q        <= src_a_i;
            b_q        <= src_b_i;
            wcnt       <= '0;
            neg_q      <= in_sgn && (src_a_i[31] ^ src_b_i[31]);
            neg_r      <= in_sgn && src_a_i[31];
            isrem_q    <= in_rem;
            spec_q     <= in_dz || in_ovf;
            spec_res_q <= spec_val;
            if (!in_div) begin
              state <= MUL_WAIT;
            end else if (fast) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= spec_val;
            end else begin
              state <= DIV_RUN;
            end
          end
        end
        MUL_WAIT: begin
          // Ready is ignored in the cycle the start pulse goes out.
          if (flush_i) begin
            state <= IDLE;
          end else if ((wcnt != '0) && mul_ready_i) begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= mul_res;
          end else if (wcnt == CW'(TIMEOUT_CYC - 1)) begin
            state    <= DONE;
            done_o   <= 1'b1;
            err_o    <= 1'b1;
            result_o <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DIV_RUN: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (div_last) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= div_res;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: vector table, corner sequences and random ops vs a model.
module tb_mdu_ctrl;

  localparam int TO = 64;

  localparam logic [4:0] M_MUL    = 5'b01011;
  localparam logic [4:0] M_MULH   = 5'b01100;
  localparam logic [4:0] M_MULHSU = 5'b01101;
  localparam logic [4:0] M_MULHU  = 5'b01110;
  localparam logic [4:0] M_DIV    = 5'b01111;
  localparam logic [4:0] M_DIVU   = 5'b10000;
  localparam logic [4:0] M_REM    = 5'b10001;
  localparam logic [4:0] M_REMU   = 5'b10010;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          rd;
    bit          early;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [4:0]  alu_op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        err_o;
  logic        mul_start_o;
  logic [1:0]  mul_opcode_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .alu_op_i     (alu_op_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .err_o        (err_o),
    .mul_start_o  (mul_start_o),
    .mul_opcode_o (mul_opcode_o),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_result_i (mul_result_i),
    .mul_ready_i  (mul_ready_i)
  );

  always #5 clk = ~clk;

  // External multiplier: full 64-bit product of the presented operands.
  always_comb begin
    case (mul_opcode_o)
      2'd0, 2'd1:
        mul_result_i = 64'(longint'($signed(mul_op1_o))
                       * longint'($signed(mul_op2_o)));
      2'd2:
        mul_result_i = 64'(longint'($signed(mul_op1_o))
                       * longint'({32'h0, mul_op2_o}));
      default:
        mul_result_i = {32'h0, mul_op1_o} * {32'h0, mul_op2_o};
    endcase
  end

  function automatic bit is_mul(input logic [4:0] op);
    return (op >= M_MUL) && (op <= M_MULHU);
  endfunction

  function automatic logic [31:0] model_res(
    input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    bit ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      M_MUL: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        return p[31:0];
      end
      M_MULH: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        return p[63:32];
      end
      M_MULHSU: begin
        p = 64'(longint'($signed(a)) * longint'({32'h0, b}));
        return p[63:32];
      end
      M_MULHU: begin
        p = {32'h0, a} * {32'h0, b};
        return p[63:32];
      end
      M_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(int'(a) / int'(b));
      end
      M_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(int'(a) % int'(b));
      end
      M_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit model_err(input vec_t v);
    return is_mul(v.op) && (v.rd == 0 || v.rd > TO);
  endfunction

  function automatic int model_lat(input vec_t v);
    int r;
    if (is_mul(v.op)) begin
      if (v.rd == 0 || v.rd > TO) return TO + 1;
      r = (v.rd < 2) ? 2 : v.rd;
      return r + 1;
    end
`ifdef MDU_DIV_FASTPATH_EN
    if (v.b == 0) return 1;
    if ((v.op == M_DIV || v.op == M_REM) && v.a == 32'h8000_0000
        && v.b == 32'hFFFF_FFFF) return 1;
`endif
    return 34;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int starts;
    bit stall_bad;
    bit port_bad;
    bit got;
    logic [31:0] res;
    logic [31:0] expr;
    logic err;
    logic [1:0] mopc;
    string tag;
    lat = -1; starts = 0; stall_bad = 0; port_bad = 0;
    got = 0; res = '0; err = 1'b0;
    mopc = 2'(v.op - M_MUL);
    expr = model_err(v) ? 32'h0 : v.exp;
    tag = $sformatf("op%h a=%h b=%h", v.op, v.a, v.b);
    alu_op_i = v.op; src_a_i = v.a; src_b_i = v.b;
    start_i = 1'b1; mul_ready_i = 1'b0;
    #1;
    check({tag, " accept_stall"}, 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    alu_op_i = 5'($urandom);
    src_a_i = $urandom;
    src_b_i = $urandom;
    for (int k = 1; k <= TO + 40 && !got; k++) begin
      mul_ready_i = (v.early && k == 1) || (v.rd != 0 && k >= v.rd);
      #1;
      if (mul_start_o === 1'b1) starts++;
      if (is_mul(v.op) && done_o !== 1'b1) begin
        if (mul_op1_o !== v.a || mul_op2_o !== v.b
            || mul_opcode_o !== mopc) port_bad = 1;
      end else if (mul_op1_o !== 0 || mul_op2_o !== 0
                   || mul_opcode_o !== 0) begin
        port_bad = 1;
      end
      if (done_o === 1'b1) begin
        got = 1; lat = k; res = result_o; err = err_o;
        if (stall_o !== 1'b0) stall_bad = 1;
      end else if (stall_o !== 1'b1) begin
        stall_bad = 1;
      end
      @(posedge clk); #1;
    end
    mul_ready_i = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(model_lat(v)));
    check({tag, " result"}, res, expr);
    check({tag, " err"}, 32'(err), 32'(model_err(v)));
    check({tag, " stall"}, 32'(stall_bad), 32'd0);
    check({tag, " starts"}, 32'(starts), is_mul(v.op) ? 32'd1 : 32'd0);
    check({tag, " mulports"}, 32'(port_bad), 32'd0);
    #1;
    check({tag, " done_pulse"}, 32'(done_o), 32'd0);
    check({tag, " err_after"}, 32'(err_o), 32'd0);
    check({tag, " result_hold"}, result_o, expr);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int dones;

    rst = 1'b1; start_i = 1'b0; alu_op_i = '0;
    src_a_i = '0; src_b_i = '0; flush_i = 1'b0; mul_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result_o, 32'h0);
    check("rst_flags",
          32'({stall_o, done_o, err_o, mul_start_o, mul_opcode_o}), 32'h0);
    check("rst_mulops", mul_op1_o | mul_op2_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Non-M op is ignored.
    start_i = 1'b1; alu_op_i = 5'b00011; src_a_i = 5; src_b_i = 6;
    #1;
    check("nonm_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    check("nonm_idle", 32'({stall_o, done_o, mul_start_o}), 32'd0);

    // Flush in the accept cycle blocks the accept.
    @(posedge clk); #1;
    start_i = 1'b1; alu_op_i = M_DIV; flush_i = 1'b1;
    #1;
    check("flushacc_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("flushacc_idle", 32'({stall_o, done_o}), 32'd0);
    @(posedge clk); #1;

    tbl.push_back('{M_MUL,    32'd7,        32'hFFFF_FFFD, 5,  0, 32'hFFFF_FFEB});
    tbl.push_back('{M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, 32'hFFFF_FFFE});
    tbl.push_back('{M_MULH,   32'h8000_0000, 32'h8000_0000, 2, 0, 32'h4000_0000});
    tbl.push_back('{M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF});
    tbl.push_back('{M_MUL,    32'd12345,    32'd3,         0,  0, 32'h0});
    tbl.push_back('{M_MULHU,  32'hFFFF_FFFF, 32'd2,        TO, 0, 32'h1});
    tbl.push_back('{M_MUL,    32'd3,        32'd5,      TO + 1, 0, 32'h0});
    tbl.push_back('{M_DIV,    32'hFFFF_FFEC, 32'd3,        0,  0, 32'hFFFF_FFFA});
    tbl.push_back('{M_REM,    32'hFFFF_FFEC, 32'd3,        0,  0, 32'hFFFF_FFFE});
    tbl.push_back('{M_DIVU,   32'd100,      32'd0,         0,  0, 32'hFFFF_FFFF});
    tbl.push_back('{M_REMU,   32'd100,      32'd0,         0,  0, 32'd100});
    tbl.push_back('{M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000});
    tbl.push_back('{M_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0});
    tbl.push_back('{M_DIV,    32'd7,        32'hFFFF_FFFE, 0,  0, 32'hFFFF_FFFD});
    tbl.push_back('{M_REM,    32'd7,        32'hFFFF_FFFE, 0,  0, 32'd1});
    tbl.push_back('{M_DIVU,   32'hFFFF_FFFF, 32'd1,        0,  0, 32'hFFFF_FFFF});
    tbl.push_back('{M_REM,    32'hFFFF_FFF9, 32'd0,        0,  0, 32'hFFFF_FFF9});
    tbl.push_back('{M_DIV,    32'hFFFF_FFF9, 32'd0,        0,  0, 32'hFFFF_FFFF});
    tbl.push_back('{M_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0});
    tbl.push_back('{M_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000});

    foreach (tbl[i]) run_op(tbl[i]);

    // Flush in cycle T+10 of a divide.
    @(posedge clk); #1;
    start_i = 1'b1; alu_op_i = M_DIV; src_a_i = 100; src_b_i = 7;
    @(posedge clk); #1;
    start_i = 1'b0;
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) flush_i = 1'b1;
      #1;
      if (done_o === 1'b1) dones++;
      @(posedge clk); #1;
    end
    flush_i = 1'b0;
    #1;
    check("flush_stall", 32'(stall_o), 32'd0);
    check("flush_done", 32'(done_o), 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (done_o === 1'b1) dones++;
      @(posedge clk); #1;
    end
    check("flush_nodone", 32'(dones), 32'd0);
    v = '{M_MUL, 32'd6, 32'd7, 2, 0, 32'd42};
    run_op(v);

    // Reset in the middle of a divide.
    start_i = 1'b1; alu_op_i = M_DIV; src_a_i = 1000; src_b_i = 3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_result", result_o, 32'h0);
    check("midrst_flags",
          32'({stall_o, done_o, err_o, mul_start_o, mul_opcode_o}), 32'h0);
    check("midrst_mulops", mul_op1_o | mul_op2_o, 32'h0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o === 1'b1) dones++;
      @(posedge clk); #1;
    end
    check("midrst_nodone", 32'(dones), 32'd0);

    for (int i = 0; i < 40; i++) begin
      v.op = 5'(32'(M_MUL) + $urandom_range(0, 7));
      v.a = $urandom;
      v.b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) v.b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 9) == 0) begin
        v.a = 32'h8000_0000;
        v.b = 32'hFFFF_FFFF;
      end
      v.rd = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
      v.early = 1'($urandom_range(0, 1));
      v.exp = model_res(v.op, v.a, v.b);
      run_op(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
